// File: rtl/cu16_pkg.sv
// Shared types and encodings for the 16-bit RISC control unit.
package cu16_pkg;

  localparam int unsigned XLEN   = 16;
  localparam int unsigned RADR_W = 4;
  localparam int unsigned FN_W   = 4;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ALU  = 4'h1;
  localparam logic [3:0] OP_LDI  = 4'h2;
  localparam logic [3:0] OP_LD   = 4'h3;
  localparam logic [3:0] OP_ST   = 4'h4;
  localparam logic [3:0] OP_BR   = 4'h6;
  localparam logic [3:0] OP_JR   = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hE;

  localparam logic [3:0] BR_AL = 4'h0;
  localparam logic [3:0] BR_Z  = 4'h1;
  localparam logic [3:0] BR_NZ = 4'h2;
  localparam logic [3:0] BR_N  = 4'h3;
  localparam logic [3:0] BR_C  = 4'h4;

  localparam logic [1:0] SSEL_REG = 2'b00;
  localparam logic [1:0] SSEL_IMM = 2'b01;
  localparam logic [1:0] SSEL_MDR = 2'b10;

  localparam logic [FN_W-1:0] ALU_PASS_S = 4'b0000;

  typedef enum logic [3:0] {
    ST_RST, ST_FETCH, ST_DECODE, ST_EXEC, ST_LOAD,
    ST_LDWB, ST_STORE, ST_BRANCH, ST_HALT, ST_FAULT
  } state_e;

  typedef struct packed {
    logic [3:0]        op;
    logic [RADR_W-1:0] rd;
    logic [RADR_W-1:0] rs;
    logic [FN_W-1:0]   fn;
  } ir_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
  } flags_t;

  function automatic logic br_cond_ok(input logic [3:0] cond);
    return cond <= BR_C;
  endfunction

  function automatic logic br_taken(input logic [3:0] cond, input flags_t f);
    logic t;
    case (cond)
      BR_AL:   t = 1'b1;
      BR_Z:    t = f.z;
      BR_NZ:   t = ~f.z;
      BR_N:    t = f.n;
      BR_C:    t = f.c;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  function automatic logic [XLEN-1:0] sext8(input logic [7:0] v);
    return {{(XLEN-8){v[7]}}, v};
  endfunction

endpackage

// File: rtl/cu16_wait_timer.sv
// Counts consecutive stalled request cycles; flags expiry on the MAX_WAIT-th stalled cycle.
module cu16_wait_timer #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic rdy,
  output logic expired_c
);

  localparam int unsigned CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
  localparam int unsigned LAST  = (MAX_WAIT == 0) ? 0 : MAX_WAIT - 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Ready in the expiry cycle wins because expiry is only raised while stalled.
  always_comb begin
    cnt_d     = '0;
    expired_c = 1'b0;
    if (req && !rdy) begin
      cnt_d     = cnt_q + CNT_W'(1);
      expired_c = (MAX_WAIT != 0) && (cnt_q == CNT_W'(LAST));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/cu16_control_fsm.sv
// Multi-cycle fetch/decode/execute control unit for the 16-bit RISC core.
module cu16_control_fsm
  import cu16_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [XLEN-1:0]   Mem_Din,
  input  logic              Mem_Rdy,
  input  logic              N,
  input  logic              Z,
  input  logic              C,
  output logic              Mem_Rd,
  output logic              Mem_Wr,
  output logic              Adr_Sel,
  output logic              IR_Ld,
  output logic              PC_Inc,
  output logic              PC_Ld,
  output logic              PC_Sel,
  output logic              MDR_Ld,
  output logic [RADR_W-1:0] R_Adr,
  output logic [RADR_W-1:0] S_Adr,
  output logic [RADR_W-1:0] W_Adr,
  output logic              W_En,
  output logic [1:0]        S_Sel,
  output logic [FN_W-1:0]   Alu_Op,
  output logic [XLEN-1:0]   Imm,
  output logic              Halted,
  output logic              Fault
);

  state_e state_q, state_d;
  ir_t    ir_q, ir_d;
  flags_t flags_q, flags_d;
  logic   req_c, expired_c;

  assign req_c = (state_q == ST_FETCH) || (state_q == ST_LOAD) || (state_q == ST_STORE);

  cu16_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk       (clk),
    .rst_n     (reset_n),
    .req       (req_c),
    .rdy       (Mem_Rdy),
    .expired_c (expired_c)
  );

  assign R_Adr = ir_q.rd;
  assign S_Adr = ir_q.rs;
  assign W_Adr = ir_q.rd;
  assign Imm   = sext8({ir_q.rs, ir_q.fn});

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    flags_d = flags_q;
    Mem_Rd  = 1'b0;
    Mem_Wr  = 1'b0;
    Adr_Sel = 1'b0;
    IR_Ld   = 1'b0;
    PC_Inc  = 1'b0;
    PC_Ld   = 1'b0;
    PC_Sel  = 1'b0;
    MDR_Ld  = 1'b0;
    W_En    = 1'b0;
    S_Sel   = SSEL_REG;
    Alu_Op  = ALU_PASS_S;
    Halted  = 1'b0;
    Fault   = 1'b0;

    case (state_q)
      ST_RST: state_d = ST_FETCH;
      ST_FETCH: begin
        Mem_Rd = 1'b1;
        if (Mem_Rdy) begin
          IR_Ld   = 1'b1;
          PC_Inc  = 1'b1;
          ir_d    = ir_t'(Mem_Din);
          state_d = ST_DECODE;
        end else if (expired_c) begin
          state_d = ST_FAULT;
        end
      end
      ST_DECODE: begin
        case (ir_q.op)
          OP_NOP:         state_d = ST_FETCH;
          OP_ALU, OP_LDI: state_d = ST_EXEC;
          OP_LD:          state_d = ST_LOAD;
          OP_ST:          state_d = ST_STORE;
          OP_BR:          state_d = br_cond_ok(ir_q.rd) ? ST_BRANCH : ST_FAULT;
          OP_JR:          state_d = ST_BRANCH;
          OP_HALT:        state_d = ST_HALT;
          default:        state_d = ST_FAULT;
        endcase
      end
      ST_EXEC: begin
        W_En    = 1'b1;
        state_d = ST_FETCH;
        if (ir_q.op == OP_ALU) begin
          Alu_Op  = ir_q.fn;
          flags_d = '{n: N, z: Z, c: C};
        end else begin
          S_Sel = SSEL_IMM;
        end
      end
      ST_LOAD: begin
        Mem_Rd  = 1'b1;
        Adr_Sel = 1'b1;
        if (Mem_Rdy) begin
          MDR_Ld  = 1'b1;
          state_d = ST_LDWB;
        end else if (expired_c) begin
          state_d = ST_FAULT;
        end
      end
      ST_LDWB: begin
        S_Sel   = SSEL_MDR;
        W_En    = 1'b1;
        state_d = ST_FETCH;
      end
      ST_STORE: begin
        Mem_Wr  = 1'b1;
        Adr_Sel = 1'b1;
        if (Mem_Rdy)        state_d = ST_FETCH;
        else if (expired_c) state_d = ST_FAULT;
      end
      // Conditions are evaluated against the registered flags only.
      ST_BRANCH: begin
        state_d = ST_FETCH;
        if (ir_q.op == OP_JR) begin
          PC_Ld  = 1'b1;
          PC_Sel = 1'b1;
        end else begin
          PC_Ld = br_taken(ir_q.rd, flags_q);
        end
      end
      ST_HALT:  Halted  = 1'b1;
      ST_FAULT: Fault   = 1'b1;
      default:  state_d = ST_FAULT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RST;
      ir_q    <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
    end
  end

endmodule

// File: tb/tb_cu16_control_fsm.sv
// Directed and randomized instruction streams checked against a per-instruction timing model.
module tb_cu16_control_fsm;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] Mem_Din;
  logic        Mem_Rdy;
  logic        N, Z, C;
  logic        Mem_Rd, Mem_Wr, Adr_Sel, IR_Ld, PC_Inc, PC_Ld, PC_Sel, MDR_Ld;
  logic [3:0]  R_Adr, S_Adr, W_Adr;
  logic        W_En;
  logic [1:0]  S_Sel;
  logic [3:0]  Alu_Op;
  logic [15:0] Imm;
  logic        Halted, Fault;

  typedef struct packed {
    logic rd, wr, adr, irld, pcinc, pcld, pcsel, mdrld, wen;
    logic [1:0] ssel;
    logic [3:0] aluop;
    logic halted, fault;
  } strb_t;

  strb_t       obs_s;
  int          total = 0;
  int          bad   = 0;
  logic [15:0] m_ir;
  logic [2:0]  m_flags;  // {n, z, c}
  logic [15:0] ins;

  always #5 clk = ~clk;

  cu16_control_fsm #(.MAX_WAIT(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .Mem_Din (Mem_Din),
    .Mem_Rdy (Mem_Rdy),
    .N       (N),
    .Z       (Z),
    .C       (C),
    .Mem_Rd  (Mem_Rd),
    .Mem_Wr  (Mem_Wr),
    .Adr_Sel (Adr_Sel),
    .IR_Ld   (IR_Ld),
    .PC_Inc  (PC_Inc),
    .PC_Ld   (PC_Ld),
    .PC_Sel  (PC_Sel),
    .MDR_Ld  (MDR_Ld),
    .R_Adr   (R_Adr),
    .S_Adr   (S_Adr),
    .W_Adr   (W_Adr),
    .W_En    (W_En),
    .S_Sel   (S_Sel),
    .Alu_Op  (Alu_Op),
    .Imm     (Imm),
    .Halted  (Halted),
    .Fault   (Fault)
  );

  assign obs_s = strb_t'({Mem_Rd, Mem_Wr, Adr_Sel, IR_Ld, PC_Inc, PC_Ld, PC_Sel, MDR_Ld,
                          W_En, S_Sel, Alu_Op, Halted, Fault});

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // One clock: check strobes and IR-derived fields at the falling edge.
  task automatic step(input string tag, input strb_t e);
    @(negedge clk);
    chk(tag, 32'(obs_s), 32'(e));
    chk({tag, "/fields"}, 32'({R_Adr, S_Adr, W_Adr, Imm}),
        32'({m_ir[11:8], m_ir[7:4], m_ir[11:8], 16'($signed(m_ir[7:0]))}));
    @(posedge clk);
    #1;
  endtask

  task automatic rand_flags();
    {N, Z, C} = 3'($urandom);
  endtask

  task automatic rand_all();
    rand_flags();
    Mem_Rdy = 1'($urandom);
    Mem_Din = 16'($urandom);
  endtask

  function automatic logic br_model(input logic [3:0] cnd);
    logic t;
    case (cnd)
      4'd0:    t = 1'b1;
      4'd1:    t = m_flags[1];
      4'd2:    t = ~m_flags[1];
      4'd3:    t = m_flags[2];
      4'd4:    t = m_flags[0];
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  function automatic logic [15:0] gen_instr();
    logic [11:0] b;
    b = 12'($urandom);
    case ($urandom_range(0, 7))
      0:       return {4'h0, b};
      1:       return {4'h1, b};
      2:       return {4'h2, b};
      3:       return {4'h3, b};
      4:       return {4'h4, b};
      6:       return {4'h7, b};
      default: return {4'h6, 4'($urandom_range(0, 4)), b[7:0]};
    endcase
  endfunction

  task automatic do_reset();
    strb_t e;
    e = '0;
    reset_n = 1'b0;
    m_ir    = '0;
    m_flags = '0;
    for (int i = 0; i < 2; i++) begin
      rand_all();
      step("in_reset", e);
    end
    reset_n = 1'b1;
    rand_all();
    step("rst_state", e);
  endtask

  task automatic fetch_dec(input logic [15:0] w, input int fw);
    strb_t e;
    for (int i = 0; i <= fw; i++) begin
      rand_flags();
      Mem_Rdy = (i == fw);
      Mem_Din = (i == fw) ? w : 16'($urandom);
      e = '0;
      e.rd    = 1'b1;
      e.irld  = (i == fw);
      e.pcinc = (i == fw);
      step("fetch", e);
    end
    m_ir = w;
    rand_all();
    e = '0;
    step("decode", e);
  endtask

  task automatic terminal(input logic is_halt);
    strb_t e;
    for (int k = 0; k < 3; k++) begin
      rand_all();
      e = '0;
      e.halted = is_halt;
      e.fault  = ~is_halt;
      step(is_halt ? "halted" : "fault", e);
    end
  endtask

  // ctl[3]=1 forces NZC=ctl[2:0] in an ALU execute cycle.
  task automatic run_instr(input logic [15:0] w, input int fw, input int mw, input logic [3:0] ctl);
    strb_t      e;
    logic [2:0] nzc;
    fetch_dec(w, fw);
    e = '0;
    case (w[15:12])
      4'h0: ;
      4'h1: begin
        rand_all();
        if (ctl[3]) {N, Z, C} = ctl[2:0];
        nzc = {N, Z, C};
        e.wen   = 1'b1;
        e.aluop = w[3:0];
        step("exec_alu", e);
        m_flags = nzc;
      end
      4'h2: begin
        rand_all();
        e.wen  = 1'b1;
        e.ssel = 2'b01;
        step("exec_ldi", e);
      end
      4'h3: begin
        for (int i = 0; i <= mw; i++) begin
          rand_flags();
          Mem_Rdy = (i == mw);
          e = '0;
          e.rd    = 1'b1;
          e.adr   = 1'b1;
          e.mdrld = (i == mw);
          step("load", e);
        end
        rand_all();
        e = '0;
        e.ssel = 2'b10;
        e.wen  = 1'b1;
        step("ldwb", e);
      end
      4'h4: begin
        for (int i = 0; i <= mw; i++) begin
          rand_flags();
          Mem_Rdy = (i == mw);
          e = '0;
          e.wr  = 1'b1;
          e.adr = 1'b1;
          step("store", e);
        end
      end
      4'h6: begin
        if (w[11:8] <= 4'd4) begin
          rand_all();
          e.pcld = br_model(w[11:8]);
          step("branch", e);
        end else begin
          terminal(1'b0);
        end
      end
      4'h7: begin
        rand_all();
        e.pcld  = 1'b1;
        e.pcsel = 1'b1;
        step("jr", e);
      end
      4'hE:    terminal(1'b1);
      default: terminal(1'b0);
    endcase
  endtask

  task automatic peek_imm(input logic [15:0] exp_imm);
    strb_t e;
    e = '0;
    e.rd = 1'b1;
    Mem_Rdy = 1'b0;
    rand_flags();
    step("fetch_wait", e);
    chk("imm_sext", 32'(Imm), 32'(exp_imm));
  endtask

  task automatic fetch_timeout();
    strb_t e;
    for (int i = 0; i < 4; i++) begin
      rand_flags();
      Mem_Rdy = 1'b0;
      Mem_Din = 16'($urandom);
      e = '0;
      e.rd = 1'b1;
      step("to_fetch", e);
    end
    terminal(1'b0);
  endtask

  task automatic store_reset();
    strb_t e;
    fetch_dec(16'h4120, 0);
    rand_flags();
    Mem_Rdy = 1'b0;
    e = '0;
    e.wr  = 1'b1;
    e.adr = 1'b1;
    step("st_wait", e);
    #2;
    chk("st_wr_pre", 32'(Mem_Wr), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("st_wr_async", 32'({Mem_Wr, Mem_Rd, Adr_Sel, W_En}), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    Mem_Rdy = 1'b0;
    Mem_Din = '0;
    {N, Z, C} = 3'b000;
    m_ir    = '0;
    m_flags = '0;
    @(posedge clk);
    #1;
    do_reset();

    run_instr(16'h1124, 0, 0, 4'h0);
    run_instr(16'h1A35, 0, 0, 4'b1010);
    run_instr(16'h6180, 1, 0, 4'h0);
    peek_imm(16'hFF80);
    run_instr(16'h1A35, 0, 0, 4'b1000);
    run_instr(16'h6180, 0, 0, 4'h0);
    run_instr(16'h3050, 0, 3, 4'h0);
    run_instr(16'h4321, 2, 3, 4'h0);

    repeat (80) begin
      ins = gen_instr();
      run_instr(ins, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 4'h0);
    end

    do_reset();
    fetch_timeout();
    do_reset();
    run_instr(16'h2A7F, 3, 0, 4'h0);
    run_instr(16'h6C00 & 16'h60FF | 16'h0200, 0, 0, 4'h0);

    run_instr(16'hE000, 1, 0, 4'h0);
    do_reset();
    run_instr(16'hF000, 0, 0, 4'h0);
    do_reset();
    run_instr(16'h6900, 0, 0, 4'h0);
    do_reset();

    run_instr(16'h1567, 0, 0, 4'b1111);
    store_reset();
    do_reset();
    run_instr(16'h6101, 0, 0, 4'h0);
    run_instr(16'h6202, 1, 0, 4'h0);
    run_instr(16'h6303, 0, 0, 4'h0);
    run_instr(16'h6404, 2, 0, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
